// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency main-memory port between the icache and dcache
// miss handlers. Grants use round-robin priority. A dirty dcache eviction is
// written back before its refill read. The line is returned with a one-cycle
// ready pulse.
module mem_port_arbiter #(
    parameter int ADDR_W  = 26,
    parameter int LINE_W  = 128,
    parameter int MEM_LAT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    input  logic              dc_req,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic              dc_wb,
    input  logic [ADDR_W-1:0] dc_wb_addr,
    input  logic [LINE_W-1:0] dc_wb_data,
    output logic              ic_ready,
    output logic              dc_ready,
    output logic              dc_wb_ack,
    output logic [LINE_W-1:0] rdata,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_WB, S_RD, S_RESP} state_e;
    typedef enum logic {OWN_I, OWN_D} owner_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    owner_e            owner_q, owner_d;
    owner_e            last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [LINE_W-1:0] wb_data_q, wb_data_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;

    logic              ic_ready_q, ic_ready_d;
    logic              dc_ready_q, dc_ready_d;
    logic              dc_wb_ack_q, dc_wb_ack_d;
    logic              busy_q, busy_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;

    logic grant_dc;
    logic grant_ic;
    logic cnt_last;

    // D wins when alone, or when both request and I was granted last
    assign grant_dc = dc_req && (!ic_req || (last_grant_q == OWN_I));
    assign grant_ic = ic_req && !grant_dc;
    assign cnt_last = (cnt_q == CNT_LAST);

    // State, latched request data and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            owner_q      <= OWN_I;
            last_grant_q <= OWN_I;
            rd_addr_q    <= '0;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
            rdata_q      <= '0;
            ic_ready_q   <= 1'b0;
            dc_ready_q   <= 1'b0;
            dc_wb_ack_q  <= 1'b0;
            busy_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            rd_addr_q    <= rd_addr_d;
            wb_addr_q    <= wb_addr_d;
            wb_data_q    <= wb_data_d;
            rdata_q      <= rdata_d;
            ic_ready_q   <= ic_ready_d;
            dc_ready_q   <= dc_ready_d;
            dc_wb_ack_q  <= dc_wb_ack_d;
            busy_q       <= busy_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // Next-state: arbitration in IDLE, latency counting in WB and RD
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        rd_addr_d    = rd_addr_q;
        wb_addr_d    = wb_addr_q;
        wb_data_d    = wb_data_q;
        rdata_d      = rdata_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (grant_dc) begin
                    owner_d      = OWN_D;
                    last_grant_d = OWN_D;
                    rd_addr_d    = dc_addr;
                    wb_addr_d    = dc_wb_addr;
                    wb_data_d    = dc_wb_data;
                    state_d      = dc_wb ? S_WB : S_RD;
                end else if (grant_ic) begin
                    owner_d      = OWN_I;
                    last_grant_d = OWN_I;
                    rd_addr_d    = ic_addr;
                    state_d      = S_RD;
                end
            end
            S_WB: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = S_RD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RD: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    rdata_d = mem_rdata;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output next values are decoded from the upcoming state so that every
    // output is registered yet lines up with the state it describes
    always_comb begin
        ic_ready_d  = (state_d == S_RESP) && (owner_d == OWN_I);
        dc_ready_d  = (state_d == S_RESP) && (owner_d == OWN_D);
        dc_wb_ack_d = (state_q == S_WB) && (state_d == S_RD);
        busy_d      = (state_d != S_IDLE);
        mem_req_d   = (state_d == S_WB) || (state_d == S_RD);
        mem_we_d    = (state_d == S_WB);
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (state_d == S_WB) begin
            mem_addr_d  = wb_addr_d;
            mem_wdata_d = wb_data_d;
        end else if (state_d == S_RD) begin
            mem_addr_d  = rd_addr_d;
        end
    end

    assign ic_ready  = ic_ready_q;
    assign dc_ready  = dc_ready_q;
    assign dc_wb_ack = dc_wb_ack_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
